// File: rtl/ring_counter_gen.sv
// ring_counter_gen: ring / Johnson counter with direction, checked load, index tracking and wrap/err pulses
module ring_counter_gen #(
  parameter int WIDTH = 4,
  parameter int MODE  = 0,
  localparam int N    = (MODE == 0) ? WIDTH : 2 * WIDTH,
  localparam int IW   = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] out,
  output logic [IW-1:0]    idx,
  output logic             wrap,
  output logic             err
);
  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ONES = '1;
  localparam logic [WIDTH-1:0] IDX0 = (MODE == 0) ? ONE : '0;
  localparam logic             TW   = (MODE != 0);
  localparam logic [IW-1:0]    LAST = IW'(N - 1);
  logic [WIDTH-1:0] out_q, out_d, fwd_out, rev_out;
  logic [IW-1:0]    idx_q, idx_d, fwd_idx, rev_idx, lv_idx;
  logic             wrap_q, wrap_d, err_q, err_d, lv_ok;
  // Johnson low half is ones filled from bit 0, high half is ones shifted up by s
  always_comb begin
    lv_ok  = 1'b0;
    lv_idx = '0;
    if (MODE == 0) begin
      for (int i = 0; i < WIDTH; i++)
        if (load_val == (ONE << i)) begin
          lv_ok  = 1'b1;
          lv_idx = IW'(i);
        end
    end else begin
      for (int i = 0; i <= WIDTH; i++)
        if (load_val == ~(ONES << i)) begin
          lv_ok  = 1'b1;
          lv_idx = IW'(i);
        end
      for (int i = 1; i < WIDTH; i++)
        if (load_val == (ONES << i)) begin
          lv_ok  = 1'b1;
          lv_idx = IW'(WIDTH + i);
        end
    end
  end
  assign fwd_out = {out_q[WIDTH-2:0], out_q[WIDTH-1] ^ TW};
  assign rev_out = {out_q[0] ^ TW, out_q[WIDTH-1:1]};
  assign fwd_idx = (idx_q == LAST) ? '0 : idx_q + IW'(1);
  assign rev_idx = (idx_q == '0) ? LAST : idx_q - IW'(1);
  always_comb begin
    out_d  = out_q;
    idx_d  = idx_q;
    wrap_d = 1'b0;
    err_d  = 1'b0;
    if (load) begin
      out_d = lv_ok ? load_val : IDX0;
      idx_d = lv_ok ? lv_idx : '0;
      err_d = !lv_ok;
    end else if (en) begin
      out_d  = dir ? rev_out : fwd_out;
      idx_d  = dir ? rev_idx : fwd_idx;
      wrap_d = dir ? (idx_q == '0) : (idx_q == LAST);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      out_q  <= IDX0;
      idx_q  <= '0;
      wrap_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      out_q  <= out_d;
      idx_q  <= idx_d;
      wrap_q <= wrap_d;
      err_q  <= err_d;
    end
  end
  assign out  = out_q;
  assign idx  = idx_q;
  assign wrap = wrap_q;
  assign err  = err_q;
endmodule
